// File: rtl/inst_mem_loader_if.sv
// Bundle of the CPU fetch port and the byte-serial loader handshake for inst_mem_loader.
// The master side is the CPU/host pair; the slave side is the memory block.
interface inst_mem_loader_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  ce;
    logic [31:0]           addr;
    logic [31:0]           inst;
    logic                  load_en;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  load_done;
    logic [DEPTH_LOG2:0]   word_count;

    modport master (
        output ce, addr, load_en, byte_valid, byte_data,
        input  inst, byte_ready, load_done, word_count
    );

    modport slave (
        input  ce, addr, load_en, byte_valid, byte_data,
        output inst, byte_ready, load_done, word_count
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Writable instruction memory: fetched like a ROM by the CPU, filled little-endian
// from a byte stream while load_en is held high.
module inst_mem_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic               clk,
    input  logic               rst,
    inst_mem_loader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state_q, state_d;
    logic                  load_en_q, load_en_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           asm_word_q, asm_word_d;
    logic [DEPTH_LOG2:0]   word_count_q, word_count_d;
    logic                  load_done_q, load_done_d;

    logic                  wr_en;
    logic [31:0]           wr_data;
    logic                  load_rise, load_fall;
    logic                  byte_ready, byte_accept;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  unused_addr_bits;

    logic [31:0] mem [2**DEPTH_LOG2];

    assign load_en_d   = bus.load_en;
    assign load_rise   = bus.load_en & ~load_en_q;
    assign load_fall   = ~bus.load_en & load_en_q;
    assign byte_ready  = (state_q == LOAD);
    assign byte_accept = bus.byte_valid & byte_ready;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        byte_idx_d   = byte_idx_q;
        asm_word_d   = asm_word_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        wr_en        = 1'b0;
        wr_data      = '0;
        case (state_q)
            IDLE, DONE: begin
                if (load_rise) begin
                    state_d      = LOAD;
                    wptr_d       = '0;
                    byte_idx_d   = '0;
                    asm_word_d   = '0;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                end
            end
            LOAD: begin
                if (byte_accept) begin
                    if (byte_idx_q == 2'd3) begin
                        wr_en        = 1'b1;
                        wr_data      = {bus.byte_data, asm_word_q[23:0]};
                        wptr_d       = wptr_q + DEPTH_LOG2'(1);
                        word_count_d = word_count_q + (DEPTH_LOG2+1)'(1);
                        byte_idx_d   = '0;
                        asm_word_d   = '0;
                        if (wptr_q == '1) begin
                            state_d     = DONE;
                            load_done_d = 1'b1;
                        end
                    end else begin
                        asm_word_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
                // A byte accepted on the closing edge is already merged into asm_word_d,
                // so the pad write (if any) carries it; a completed word needs no pad.
                if (load_fall && state_d == LOAD) begin
                    state_d     = DONE;
                    load_done_d = 1'b1;
                    if (byte_idx_d != 2'd0) begin
                        wr_en        = 1'b1;
                        wr_data      = asm_word_d;
                        wptr_d       = wptr_q + DEPTH_LOG2'(1);
                        word_count_d = word_count_q + (DEPTH_LOG2+1)'(1);
                        byte_idx_d   = '0;
                        asm_word_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            load_en_q    <= 1'b0;
            wptr_q       <= '0;
            byte_idx_q   <= '0;
            asm_word_q   <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_en_q    <= load_en_d;
            wptr_q       <= wptr_d;
            byte_idx_q   <= byte_idx_d;
            asm_word_q   <= asm_word_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
        end
    end

    // Memory contents survive reset so an aborted session leaves earlier words intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= wr_data;
        end
    end

    assign rd_idx           = bus.addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

    assign bus.inst       = (bus.ce && state_q != LOAD) ? mem[rd_idx] : 32'h0;
    assign bus.byte_ready = byte_ready;
    assign bus.load_done  = load_done_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a default-depth instance and a depth-4 instance
// for the full-memory case, both sharing clock and reset.
module tb_inst_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    inst_mem_loader_if #(.DEPTH_LOG2(10)) bus ();
    inst_mem_loader_if #(.DEPTH_LOG2(2))  bus_s ();

    inst_mem_loader #(.DEPTH_LOG2(10)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    inst_mem_loader #(.DEPTH_LOG2(2)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.ce   = 1'b1;
        bus.addr = a;
        #1;
        check(tag, bus.inst, exp);
    endtask

    initial begin
        logic [7:0] prog [8];
        prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

        bus.ce = 1'b0; bus.addr = '0; bus.load_en = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_data = '0;
        bus_s.ce = 1'b0; bus_s.addr = '0; bus_s.load_en = 1'b0;
        bus_s.byte_valid = 1'b0; bus_s.byte_data = '0;

        repeat (2) tick();
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_load_done",  32'(bus.load_done),  32'd0);
        check("rst_word_count", 32'(bus.word_count), 32'd0);
        check("rst_inst_ce0",   bus.inst,            32'h0);
        rst = 1'b1;
        tick();

        // Session 1: two full words back-to-back
        bus.load_en = 1'b1;
        #1;
        check("pre_load_ready", 32'(bus.byte_ready), 32'd0);
        tick();
        check("load_ready", 32'(bus.byte_ready), 32'd1);
        fetch("inst_during_load", 32'h0, 32'h0);
        bus.ce = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i]);
            if (i == 3) check("wc_after_word0", 32'(bus.word_count), 32'd1);
        end
        bus.load_en = 1'b0;
        #1;
        check("done_before_fall", 32'(bus.load_done), 32'd0);
        tick();
        check("s1_word_count", 32'(bus.word_count), 32'd2);
        check("s1_load_done",  32'(bus.load_done),  32'd1);
        check("s1_ready_done", 32'(bus.byte_ready), 32'd0);
        fetch("s1_addr0", 32'h0, 32'h00100513);
        fetch("s1_addr4", 32'h4, 32'h00200593);
        fetch("s1_addr6", 32'h6, 32'h00200593);
        bus.ce = 1'b0;
        #1;
        check("done_inst_ce0", bus.inst, 32'h0);

        // Session 2: partial word padded on fall
        bus.load_en = 1'b1;
        tick();
        check("s2_wc_cleared", 32'(bus.word_count), 32'd0);
        check("s2_done_clr",   32'(bus.load_done),  32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.load_en = 1'b0;
        tick();
        check("s2_word_count", 32'(bus.word_count), 32'd1);
        check("s2_load_done",  32'(bus.load_done),  32'd1);
        fetch("s2_addr0", 32'h0, 32'h0000BBAA);
        fetch("s2_addr4_kept", 32'h4, 32'h00200593);

        // Session 3: gapped bytes, last byte on the same edge as the fall
        bus.ce = 1'b0;
        bus.load_en = 1'b1;
        tick();
        send_byte(8'h11); tick(); tick();
        send_byte(8'h22); tick(); tick();
        send_byte(8'h33); tick(); tick();
        bus.load_en = 1'b0;
        send_byte(8'h44);
        check("s3_word_count", 32'(bus.word_count), 32'd1);
        check("s3_load_done",  32'(bus.load_done),  32'd1);
        fetch("s3_addr0", 32'h0, 32'h44332211);
        fetch("s3_no_pad", 32'h4, 32'h00200593);
        bus.ce = 1'b0;

        // Full memory on the depth-4 instance
        bus_s.load_en = 1'b1;
        tick();
        bus_s.byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus_s.byte_data = 8'(i + 1);
            tick();
            if (i == 14) check("full_ready_b15", 32'(bus_s.byte_ready), 32'd1);
            if (i == 15) check("full_done_b16",  32'(bus_s.load_done),  32'd1);
        end
        bus_s.byte_valid = 1'b0;
        check("full_ready_after", 32'(bus_s.byte_ready), 32'd0);
        check("full_word_count",  32'(bus_s.word_count), 32'd4);
        bus_s.load_en = 1'b0;
        tick();
        bus_s.ce = 1'b1;
        bus_s.addr = 32'h10;
        #1;
        check("full_alias_0x10", bus_s.inst, 32'h04030201);
        bus_s.addr = 32'hC;
        #1;
        check("full_word3", bus_s.inst, 32'h100F0E0D);
        bus_s.ce = 1'b0;

        // Async reset mid-session, then a fresh session
        bus.load_en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send_byte(8'(8'hF0 + i));
        check("mid_wc_before_rst", 32'(bus.word_count), 32'd1);
        #2;
        rst = 1'b0;
        bus.load_en = 1'b0;
        #1;
        check("arst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("arst_load_done",  32'(bus.load_done),  32'd0);
        check("arst_word_count", 32'(bus.word_count), 32'd0);
        check("arst_inst_ce0",   bus.inst,            32'h0);
        fetch("arst_word_kept", 32'h0, 32'hF3F2F1F0);
        bus.ce = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bus.load_en = 1'b1;
        tick();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        bus.load_en = 1'b0;
        tick();
        check("s5_word_count", 32'(bus.word_count), 32'd1);
        check("s5_load_done",  32'(bus.load_done),  32'd1);
        fetch("s5_addr0", 32'h0, 32'h04030201);
        fetch("s5_addr4", 32'h4, 32'h00200593);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
